blake2_block_sched: RTL and testbench

// - Sequences the BLAKE2s compression datapath from the io_intf byte stream:

---
 rtl/blake2_block_sched.sv | 205 ++++++++++++++++++++
 tb/tb_blake2_block_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2_block_sched.sv
// BLAKE2s block sequencer: io_intf bytes -> engine message buffer, padding, launch, digest readout.
// Define BLAKE2_SCHED_ERR_EN to build the sticky overrun flag on err_o; otherwise err_o is tied 0.
//
// state | meaning
// IDLE  | waiting for the first byte (idx 0, block_first_i) of a new hash
// FILL  | accepting key/message bytes of the current block
// PAD   | writing 0x00 into the unused tail of a short block
// COMP  | one-cycle compression launch
// WAIT  | engine busy, waiting for comp_done_i
// OUT   | streaming the nn-byte digest out
module blake2_block_sched #(
    parameter int BB  = 64,
    parameter int W_T = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [5:0]     kk_i,
    input  logic [5:0]     nn_i,
    input  logic [63:0]    ll_i,
    input  logic           data_v_i,
    input  logic [7:0]     data_i,
    input  logic [5:0]     data_idx_i,
    input  logic           block_first_i,
    input  logic           block_last_i,
    output logic           ready_v_o,
    output logic           msg_we_o,
    output logic [5:0]     msg_waddr_o,
    output logic [7:0]     msg_wdata_o,
    output logic           comp_start_o,
    output logic           comp_init_o,
    output logic           comp_last_o,
    output logic [W_T-1:0] comp_t_o,
    input  logic           comp_done_i,
    output logic           hash_rd_o,
    output logic [4:0]     hash_raddr_o,
    input  logic [7:0]     hash_rdata_i,
    output logic           hash_v_o,
    output logic [7:0]     hash_o,
    output logic           err_o
);
    localparam logic [6:0] BB_L = 7'(BB);

    typedef enum logic [2:0] {IDLE, FILL, PAD, COMP, WAIT, OUT} state_t;
    state_t state, state_d;

    logic [W_T-1:0] t, t_d, t_base, t_close;
    logic           first, first_d;
    logic           keyblk, keyblk_d, keyblk_eff;
    logic           final_q, final_d, final_now;
    logic [6:0]     pad_cnt, pad_cnt_d;
    logic [5:0]     nn_q, nn_d;
    logic [5:0]     rd_cnt, rd_cnt_d;
    logic [6:0]     len, idx_ext;
    logic           acc, start, fill_acc, keep, close;

    assign ready_v_o  = (state == IDLE) || (state == FILL);
    assign acc        = data_v_i && ready_v_o;
    assign idx_ext    = {1'b0, data_idx_i};
    assign start      = acc && (state == IDLE) && block_first_i && (data_idx_i == 6'd0);
    assign fill_acc   = acc && (state == FILL);
    assign keep       = (start || fill_acc) && (idx_ext < len);
    assign close      = keep && (idx_ext == len - 7'd1);
    assign keyblk_eff = (state == IDLE) ? (kk_i != 6'd0) : keyblk;
    assign final_now  = block_last_i || (keyblk_eff && (ll_i == 64'd0));

    // A new hash counts from zero even if t still holds the previous hash's total.
    assign t_base  = (state == IDLE) ? '0 : t;
    assign t_close = final_now ? (W_T'(ll_i) + ((kk_i != 6'd0) ? W_T'(BB) : '0))
                               : (t_base + W_T'(BB));

    always_comb begin
        len = BB_L;
        if (keyblk_eff) begin
            len = {1'b0, kk_i};
        end else if (block_last_i) begin
            if (ll_i == 64'd0)
                len = 7'd1;
            else if (ll_i[5:0] != 6'd0)
                len = {1'b0, ll_i[5:0]};
        end
    end

    always_comb begin
        state_d   = state;
        t_d       = t;
        first_d   = first;
        keyblk_d  = keyblk;
        final_d   = final_q;
        pad_cnt_d = pad_cnt;
        nn_d      = nn_q;
        rd_cnt_d  = rd_cnt;
        if (start) begin
            first_d  = 1'b1;
            keyblk_d = (kk_i != 6'd0);
            t_d      = '0;
            state_d  = FILL;
        end
        if (close) begin
            t_d       = t_close;
            final_d   = final_now;
            pad_cnt_d = BB_L - len;
            nn_d      = (nn_i == 6'd0) ? 6'd1 : nn_i;
            state_d   = (len < BB_L) ? PAD : COMP;
        end
        case (state)
            PAD: begin
                pad_cnt_d = pad_cnt - 7'd1;
                if (pad_cnt == 7'd1)
                    state_d = COMP;
            end
            COMP: begin
                first_d  = 1'b0;
                keyblk_d = 1'b0;
                state_d  = WAIT;
            end
            WAIT: begin
                if (comp_done_i) begin
                    state_d  = final_q ? OUT : FILL;
                    rd_cnt_d = nn_q;
                end
            end
            OUT: begin
                if (rd_cnt != 6'd0)
                    rd_cnt_d = rd_cnt - 6'd1;
                else
                    state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= IDLE;
            t            <= '0;
            first        <= 1'b0;
            keyblk       <= 1'b0;
            final_q      <= 1'b0;
            pad_cnt      <= '0;
            nn_q         <= '0;
            rd_cnt       <= '0;
            msg_we_o     <= 1'b0;
            msg_waddr_o  <= '0;
            msg_wdata_o  <= '0;
            comp_start_o <= 1'b0;
            comp_init_o  <= 1'b0;
            comp_last_o  <= 1'b0;
            comp_t_o     <= '0;
            hash_v_o     <= 1'b0;
        end else begin
            state    <= state_d;
            t        <= t_d;
            first    <= first_d;
            keyblk   <= keyblk_d;
            final_q  <= final_d;
            pad_cnt  <= pad_cnt_d;
            nn_q     <= nn_d;
            rd_cnt   <= rd_cnt_d;
            hash_v_o <= hash_rd_o;
            if (keep) begin
                msg_we_o    <= 1'b1;
                msg_waddr_o <= data_idx_i;
                msg_wdata_o <= data_i;
            end else if (state == PAD) begin
                msg_we_o    <= 1'b1;
                msg_waddr_o <= 6'(BB_L - pad_cnt);
                msg_wdata_o <= 8'h00;
            end else begin
                msg_we_o <= 1'b0;
            end
            // Launch flags are captured on entry to COMP and held until the next launch.
            comp_start_o <= (state_d == COMP);
            if (state_d == COMP) begin
                comp_t_o    <= t_d;
                comp_init_o <= first_d;
                comp_last_o <= final_d;
            end
        end
    end

    assign hash_rd_o    = (state == OUT) && (rd_cnt != 6'd0);
    assign hash_raddr_o = hash_rd_o ? 5'(nn_q - rd_cnt) : 5'd0;
    assign hash_o       = hash_v_o ? hash_rdata_i : 8'h00;

`ifdef BLAKE2_SCHED_ERR_EN
    logic err_q;
    logic err_set;

    assign err_set = (data_v_i && !ready_v_o)
                   || (acc && (state == IDLE) && !start)
                   || (fill_acc && !keep);

    always_ff @(posedge clk) begin
        if (!nreset)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_block_sched.sv
// Directed bench for blake2_block_sched: engine/digest model plus a write/launch monitor.
`timescale 1ns/1ps
module tb_blake2_block_sched;
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [5:0]  kk_i = '0;
    logic [5:0]  nn_i = '0;
    logic [63:0] ll_i = '0;
    logic        data_v_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic [5:0]  data_idx_i = '0;
    logic        block_first_i = 1'b0;
    logic        block_last_i = 1'b0;
    logic        ready_v_o, msg_we_o, comp_start_o, comp_init_o, comp_last_o;
    logic [5:0]  msg_waddr_o;
    logic [7:0]  msg_wdata_o;
    logic [63:0] comp_t_o;
    logic        comp_done_i;
    logic        hash_rd_o, hash_v_o, err_o;
    logic [4:0]  hash_raddr_o;
    logic [7:0]  hash_rdata_i = '0;
    logic [7:0]  hash_o;

    int checks = 0;
    int errors = 0;
    int eng_cnt = 0;
    logic done_force = 1'b0;

    always #5 clk = ~clk;

    blake2_block_sched dut (
        .clk(clk), .nreset(nreset), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
        .data_v_i(data_v_i), .data_i(data_i), .data_idx_i(data_idx_i),
        .block_first_i(block_first_i), .block_last_i(block_last_i),
        .ready_v_o(ready_v_o), .msg_we_o(msg_we_o), .msg_waddr_o(msg_waddr_o),
        .msg_wdata_o(msg_wdata_o), .comp_start_o(comp_start_o), .comp_init_o(comp_init_o),
        .comp_last_o(comp_last_o), .comp_t_o(comp_t_o), .comp_done_i(comp_done_i),
        .hash_rd_o(hash_rd_o), .hash_raddr_o(hash_raddr_o), .hash_rdata_i(hash_rdata_i),
        .hash_v_o(hash_v_o), .hash_o(hash_o), .err_o(err_o)
    );

    // Engine model: done 5 cycles after launch; digest byte at address a is 0x80+a.
    always @(posedge clk) begin
        if (comp_start_o)
            eng_cnt <= 5;
        else if (eng_cnt != 0)
            eng_cnt <= eng_cnt - 1;
        if (hash_rd_o)
            hash_rdata_i <= 8'h80 + {3'b000, hash_raddr_o};
    end
    assign comp_done_i = (eng_cnt == 1) || done_force;

    logic [511:0] cur_blk = {64{8'hEE}};
    logic [511:0] snap_blk [16];
    logic [63:0]  snap_t [16];
    logic         snap_init [16];
    logic         snap_last [16];
    int           snap_wr [16];
    int           snap_n = 0;
    int           wr_blk = 0;
    int           wr_tot = 0;
    int           hv_tot = 0;
    logic [7:0]   hv_data [128];

    always @(negedge clk) begin
        if (msg_we_o) begin
            cur_blk[{msg_waddr_o, 3'b000} +: 8] = msg_wdata_o;
            wr_blk++;
            wr_tot++;
        end
        if (comp_start_o && snap_n < 16) begin
            snap_blk[snap_n]  = cur_blk;
            snap_t[snap_n]    = comp_t_o;
            snap_init[snap_n] = comp_init_o;
            snap_last[snap_n] = comp_last_o;
            snap_wr[snap_n]   = wr_blk;
            snap_n++;
            wr_blk  = 0;
            cur_blk = {64{8'hEE}};
        end
        if (hash_v_o && hv_tot < 128) begin
            hv_data[hv_tot] = hash_o;
            hv_tot++;
        end
        if (!nreset) begin
            wr_blk  = 0;
            cur_blk = {64{8'hEE}};
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_snap(input string tag, input int k, input logic [63:0] t,
                            input logic init, input logic last);
        chk({tag, "_t"},    snap_t[k], t);
        chk({tag, "_init"}, 64'(snap_init[k]), 64'(init));
        chk({tag, "_last"}, 64'(snap_last[k]), 64'(last));
        chk({tag, "_wr"},   64'(snap_wr[k]), 64'd64);
    endtask

    task automatic chk_hash(input string tag, input int base, input int n);
        int nbad = 0;
        for (int i = 0; i < n; i++) begin
            if (base + i >= 128)
                nbad++;
            else if (hv_data[base + i] !== 8'h80 + 8'(i))
                nbad++;
        end
        chk({tag, "_bytes"}, 64'(nbad), 64'd0);
        chk({tag, "_cnt"}, 64'(hv_tot - base), 64'(n));
    endtask

    task automatic send_byte(input logic [5:0] idx, input logic [7:0] d,
                             input logic f, input logic l);
        int n = 0;
        while (ready_v_o !== 1'b1 && n < 500) begin
            tick(1);
            n++;
        end
        if (n >= 500)
            chk("ready_wait", 64'(ready_v_o), 64'd1);
        data_v_i = 1'b1;
        data_idx_i = idx;
        data_i = d;
        block_first_i = f;
        block_last_i = l;
        tick(1);
        data_v_i = 1'b0;
    endtask

    task automatic wait_snap(input int target);
        int n = 0;
        while (snap_n < target && n < 2000) begin
            tick(1);
            n++;
        end
        chk("snap_wait", 64'(snap_n), 64'(target));
    endtask

    task automatic wait_hv(input int target);
        int n = 0;
        while (hv_tot < target && n < 2000) begin
            tick(1);
            n++;
        end
        tick(3);
    endtask

    int sb, hb, wb;
    logic [511:0] exp_blk;

    initial begin
        tick(3);
        chk("rst_ready", 64'(ready_v_o), 64'd1);
        chk("rst_we", 64'(msg_we_o), 64'd0);
        chk("rst_start", 64'(comp_start_o), 64'd0);
        chk("rst_t", comp_t_o, 64'd0);
        chk("rst_hv", 64'(hash_v_o), 64'd0);
        chk("rst_rd", 64'(hash_rd_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        nreset = 1'b1;
        tick(2);

        // Short unkeyed message with an over-length byte in the middle.
        kk_i = 6'd0; ll_i = 64'd3; nn_i = 6'd32;
        sb = snap_n; hb = hv_tot;
        send_byte(6'd0, 8'h61, 1'b1, 1'b1);
        send_byte(6'd10, 8'hFF, 1'b1, 1'b1);
        send_byte(6'd1, 8'h62, 1'b1, 1'b1);
        send_byte(6'd2, 8'h63, 1'b1, 1'b1);
        wait_snap(sb + 1);
        chk_snap("A", sb, 64'd3, 1'b1, 1'b1);
        exp_blk = '0;
        exp_blk[23:0] = 24'h636261;
        chk_blk("A_blk", snap_blk[sb], exp_blk);
        wait_hv(hb + 32);
        chk_hash("A_hash", hb, 32);
        chk("A_idle_ready", 64'(ready_v_o), 64'd1);

        // Two full blocks, no padding.
        kk_i = 6'd0; ll_i = 64'd128; nn_i = 6'd4;
        sb = snap_n; hb = hv_tot;
        for (int i = 0; i < 64; i++) send_byte(i[5:0], i[7:0], 1'b1, 1'b0);
        wait_snap(sb + 1);
        for (int i = 0; i < 64; i++) send_byte(i[5:0], 8'h40 + i[7:0], 1'b0, 1'b1);
        wait_snap(sb + 2);
        chk_snap("B1", sb, 64'd64, 1'b1, 1'b0);
        chk_snap("B2", sb + 1, 64'd128, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) exp_blk[i*8 +: 8] = 8'h40 + i[7:0];
        chk_blk("B2_blk", snap_blk[sb + 1], exp_blk);
        wait_hv(hb + 4);
        chk_hash("B_hash", hb, 4);

        // Keyed: 4-byte key block then 1 data byte.
        kk_i = 6'd4; ll_i = 64'd1; nn_i = 6'd16;
        sb = snap_n; hb = hv_tot;
        for (int i = 0; i < 4; i++) send_byte(i[5:0], 8'h10 + i[7:0], 1'b1, 1'b0);
        wait_snap(sb + 1);
        send_byte(6'd0, 8'h55, 1'b0, 1'b1);
        wait_snap(sb + 2);
        chk_snap("C1", sb, 64'd64, 1'b1, 1'b0);
        chk_snap("C2", sb + 1, 64'd65, 1'b0, 1'b1);
        exp_blk = '0;
        exp_blk[31:0] = 32'h13121110;
        chk_blk("C1_blk", snap_blk[sb], exp_blk);
        exp_blk = '0;
        exp_blk[7:0] = 8'h55;
        chk_blk("C2_blk", snap_blk[sb + 1], exp_blk);
        wait_hv(hb + 16);
        chk_hash("C_hash", hb, 16);

        // Empty unkeyed message (dummy byte) with nn=0 treated as 1.
        kk_i = 6'd0; ll_i = 64'd0; nn_i = 6'd0;
        sb = snap_n; hb = hv_tot;
        send_byte(6'd0, 8'h00, 1'b1, 1'b1);
        wait_snap(sb + 1);
        chk_snap("D1", sb, 64'd0, 1'b1, 1'b1);
        chk_blk("D1_blk", snap_blk[sb], 512'd0);
        wait_hv(hb + 1);
        chk_hash("D1_hash", hb, 1);

        // Key block only (ll=0), final without block_last_i.
        kk_i = 6'd8; ll_i = 64'd0; nn_i = 6'd2;
        sb = snap_n; hb = hv_tot;
        for (int i = 0; i < 8; i++) send_byte(i[5:0], 8'hA0 + i[7:0], 1'b1, 1'b0);
        wait_snap(sb + 1);
        chk_snap("D2", sb, 64'd64, 1'b1, 1'b1);
        exp_blk = '0;
        exp_blk[63:0] = 64'hA7A6A5A4A3A2A1A0;
        chk_blk("D2_blk", snap_blk[sb], exp_blk);
        wait_hv(hb + 2);
        chk_hash("D2_hash", hb, 2);

        // Byte during WAIT is dropped; done pulse during FILL is ignored.
        kk_i = 6'd0; ll_i = 64'd128; nn_i = 6'd4;
        sb = snap_n; hb = hv_tot;
        for (int i = 0; i < 64; i++) send_byte(i[5:0], 8'h20 + i[7:0], 1'b1, 1'b0);
        wait_snap(sb + 1);
        wb = wr_tot;
        data_v_i = 1'b1; data_idx_i = 6'd0; data_i = 8'hCC;
        block_first_i = 1'b1; block_last_i = 1'b0;
        tick(1);
        data_v_i = 1'b0;
        tick(1);
        chk("E_wait_drop", 64'(wr_tot - wb), 64'd0);
        for (int i = 0; i < 10; i++) send_byte(i[5:0], 8'h60 + i[7:0], 1'b0, 1'b1);
        done_force = 1'b1;
        tick(1);
        done_force = 1'b0;
        tick(1);
        chk("E_fill_done_ready", 64'(ready_v_o), 64'd1);
        chk("E_fill_done_nolaunch", 64'(snap_n), 64'(sb + 1));
        for (int i = 10; i < 64; i++) send_byte(i[5:0], 8'h60 + i[7:0], 1'b0, 1'b1);
        wait_snap(sb + 2);
        chk_snap("E1", sb, 64'd64, 1'b1, 1'b0);
        chk_snap("E2", sb + 1, 64'd128, 1'b0, 1'b1);
        for (int i = 0; i < 64; i++) exp_blk[i*8 +: 8] = 8'h60 + i[7:0];
        chk_blk("E2_blk", snap_blk[sb + 1], exp_blk);
        wait_hv(hb + 4);
        chk_hash("E_hash", hb, 4);
`ifdef BLAKE2_SCHED_ERR_EN
        chk("E_err", 64'(err_o), 64'd1);
`else
        chk("E_err", 64'(err_o), 64'd0);
`endif

        // Reset while padding aborts the hash; a fresh hash starts clean.
        kk_i = 6'd0; ll_i = 64'd2; nn_i = 6'd1;
        sb = snap_n;
        send_byte(6'd0, 8'h11, 1'b1, 1'b1);
        send_byte(6'd1, 8'h22, 1'b1, 1'b1);
        tick(5);
        chk("F_in_pad", 64'(ready_v_o), 64'd0);
        nreset = 1'b0;
        tick(1);
        chk("F_rst_ready", 64'(ready_v_o), 64'd1);
        chk("F_rst_we", 64'(msg_we_o), 64'd0);
        chk("F_rst_start", 64'(comp_start_o), 64'd0);
        chk("F_rst_t", comp_t_o, 64'd0);
        chk("F_rst_init", 64'(comp_init_o), 64'd0);
        chk("F_rst_last", 64'(comp_last_o), 64'd0);
        chk("F_rst_err", 64'(err_o), 64'd0);
        nreset = 1'b1;
        tick(80);
        chk("F_no_launch", 64'(snap_n), 64'(sb));
        ll_i = 64'd3;
        hb = hv_tot;
        send_byte(6'd0, 8'h31, 1'b1, 1'b1);
        send_byte(6'd1, 8'h32, 1'b1, 1'b1);
        send_byte(6'd2, 8'h33, 1'b1, 1'b1);
        wait_snap(sb + 1);
        chk_snap("F", sb, 64'd3, 1'b1, 1'b1);
        exp_blk = '0;
        exp_blk[23:0] = 24'h333231;
        chk_blk("F_blk", snap_blk[sb], exp_blk);
        wait_hv(hb + 1);
        chk_hash("F_hash", hb, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
